// File: rtl/mc_step_sequencer.sv
// One-hot timing-step generator for the multicycle core.
// Handles memory wait states, MDU stalls, bus timeout and exception entry.
module mc_step_sequencer #(
  parameter int NSTEP = 5,
  parameter int LEN_W = 4,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] len,
  input  logic             early_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             exc_req,
  input  logic [4:0]       exc_cause_in,
  input  logic             irq,
  input  logic             irq_en,
  output logic [NSTEP-1:0] step,
  output logic             stall,
  output logic             retire,
  output logic             exc_entry,
  output logic [4:0]       exc_cause,
  output logic             irq_ack,
  output logic             bus_timeout
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] WAIT_MDU = 2'd1;
  localparam logic [1:0] EXC      = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(3);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NSTEP);
  localparam logic [TO_W-1:0]  TO_LAST = {TO_W{1'b1}} - TO_W'(1);

  logic [1:0]       state_q, state_d;
  logic [NSTEP-1:0] step_q, step_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             retire_q, retire_d;
  logic             entry_q, entry_d;
  logic [4:0]       cause_q, cause_d;
  logic             ack_q, ack_d;
  logic             bto_q, bto_d;

  logic [LEN_W-1:0] k;
  logic [LEN_W-1:0] len_clamped;
  logic             run, wmdu, mem_wait, adv, k_ge2;
  logic             fin, timeout, take_exc;

  always_comb begin
    k = '0;
    for (int i = 0; i < NSTEP; i++)
      if (step_q[i]) k = LEN_W'(i);
  end

  always_comb begin
    if (len < LEN_MIN)      len_clamped = LEN_MIN;
    else if (len > LEN_MAX) len_clamped = LEN_MAX;
    else                    len_clamped = len;
  end

  assign run      = (state_q == RUN);
  assign wmdu     = (state_q == WAIT_MDU);
  assign mem_wait = mem_req & ~mem_ready;
  assign adv      = (run & ~mem_wait & ~mdu_start)
                  | (wmdu & mdu_done);
  assign stall    = (run & (mem_wait | mdu_start))
                  | (wmdu & ~mdu_done);
  assign k_ge2    = (k >= LEN_W'(2));
  assign fin      = adv & ((k == len_q - LEN_W'(1))
                  | (early_done & k_ge2));
  assign timeout  = run & mem_wait & (to_cnt_q == TO_LAST);
  assign take_exc = adv & exc_req & k_ge2;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    to_cnt_d = to_cnt_q;
    retire_d = 1'b0;
    entry_d  = 1'b0;
    cause_d  = 5'd0;
    ack_d    = 1'b0;
    bto_d    = 1'b0;
    if (state_q == EXC) begin
      state_d  = RUN;
      step_d   = NSTEP'(1);
      to_cnt_d = '0;
    end else if (timeout) begin
      state_d  = EXC;
      step_d   = '0;
      to_cnt_d = '0;
      entry_d  = 1'b1;
      bto_d    = 1'b1;
      cause_d  = step_q[0] ? 5'd6 : 5'd7;
    end else if (run & mem_wait) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else if (take_exc) begin
      state_d  = EXC;
      step_d   = '0;
      to_cnt_d = '0;
      entry_d  = 1'b1;
      cause_d  = exc_cause_in;
    end else if (fin) begin
      retire_d = 1'b1;
      to_cnt_d = '0;
      // interrupt is taken only between instructions
      if (irq & irq_en) begin
        state_d = EXC;
        step_d  = '0;
        entry_d = 1'b1;
        ack_d   = 1'b1;
      end else begin
        state_d = RUN;
        step_d  = NSTEP'(1);
      end
    end else if (adv) begin
      state_d  = RUN;
      step_d   = {step_q[NSTEP-2:0], 1'b0};
      to_cnt_d = '0;
      if (k == LEN_W'(1)) len_d = len_clamped;
    end else if (run & mdu_start) begin
      state_d = WAIT_MDU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      step_q   <= NSTEP'(1);
      len_q    <= LEN_MAX;
      to_cnt_q <= '0;
      retire_q <= 1'b0;
      entry_q  <= 1'b0;
      cause_q  <= 5'd0;
      ack_q    <= 1'b0;
      bto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      len_q    <= len_d;
      to_cnt_q <= to_cnt_d;
      retire_q <= retire_d;
      entry_q  <= entry_d;
      cause_q  <= cause_d;
      ack_q    <= ack_d;
      bto_q    <= bto_d;
    end
  end

  assign step        = step_q;
  assign retire      = retire_q;
  assign exc_entry   = entry_q;
  assign exc_cause   = cause_q;
  assign irq_ack     = ack_q;
  assign bus_timeout = bto_q;

endmodule

// File: tb/tb_mc_step_sequencer.sv
// Bench for mc_step_sequencer: directed scenarios plus random traffic,
// checked every cycle against an index-based reference model.
module tb_mc_step_sequencer;

  localparam int NSTEP = 5;
  localparam int LEN_W = 4;
  localparam int TOW   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [LEN_W-1:0] len;
  logic             early_done, mem_req, mem_ready;
  logic             mdu_start, mdu_done, exc_req;
  logic [4:0]       exc_cause_in;
  logic             irq, irq_en;
  logic [NSTEP-1:0] step;
  logic             stall, retire, exc_entry, irq_ack, bus_timeout;
  logic [4:0]       exc_cause;

  int tests = 0;
  int fails = 0;

  mc_step_sequencer #(.NSTEP(NSTEP), .LEN_W(LEN_W), .TO_W(TOW)) dut (
    .clk(clk), .reset(reset), .len(len),
    .early_done(early_done), .mem_req(mem_req),
    .mem_ready(mem_ready), .mdu_start(mdu_start),
    .mdu_done(mdu_done), .exc_req(exc_req),
    .exc_cause_in(exc_cause_in), .irq(irq), .irq_en(irq_en),
    .step(step), .stall(stall), .retire(retire),
    .exc_entry(exc_entry), .exc_cause(exc_cause),
    .irq_ack(irq_ack), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  // reference model: step index, wait count, pending pulses
  int mk, mlen, mwait;
  bit mmdu, mexc, armed;
  bit e_ret, e_exc, e_ack, e_to;
  int e_cause;

  always @(posedge clk) begin
    if (reset) begin
      mk = 0; mlen = NSTEP; mwait = 0;
      mmdu = 0; mexc = 0; armed = 1;
      e_ret = 0; e_exc = 0; e_ack = 0; e_to = 0; e_cause = 0;
    end else if (armed) begin
      bit hold, go;
      e_ret = 0; e_exc = 0; e_ack = 0; e_to = 0; e_cause = 0;
      if (mexc) begin
        mexc = 0; mk = 0; mwait = 0;
      end else begin
        hold = !mmdu && mem_req && !mem_ready;
        go = mmdu ? mdu_done : (!hold && !mdu_start);
        if (hold) begin
          mwait++;
          if (mwait == (1 << TOW) - 1) begin
            mexc = 1; e_exc = 1; e_to = 1; mwait = 0;
            e_cause = (mk == 0) ? 6 : 7;
          end
        end else if (go) begin
          mmdu = 0; mwait = 0;
          if (exc_req && mk >= 2) begin
            mexc = 1; e_exc = 1; e_cause = exc_cause_in;
          end else if (mk == mlen - 1 || (early_done && mk >= 2)) begin
            e_ret = 1; mk = 0;
            if (irq && irq_en) begin
              mexc = 1; e_exc = 1; e_ack = 1; e_cause = 0;
            end
          end else begin
            if (mk == 1)
              mlen = (len < 3) ? 3 : (len > NSTEP) ? NSTEP : int'(len);
            mk++;
          end
        end else if (!mmdu && mdu_start) begin
          mmdu = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      bit es;
      if (mexc) es = 0;
      else if (mmdu) es = !mdu_done;
      else es = (mem_req && !mem_ready) || mdu_start;
      chk("m_step", int'(step), mexc ? 0 : (1 << mk));
      chk("m_stall", int'(stall), int'(es));
      chk("m_retire", int'(retire), int'(e_ret));
      chk("m_exc_entry", int'(exc_entry), int'(e_exc));
      chk("m_irq_ack", int'(irq_ack), int'(e_ack));
      chk("m_bus_timeout", int'(bus_timeout), int'(e_to));
      if (e_exc) chk("m_exc_cause", int'(exc_cause), e_cause);
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic nxn(input int n);
    for (int i = 0; i < n; i++) nx();
  endtask

  int seq [11] = '{1, 2, 4, 8, 16, 1, 2, 4, 8, 16, 1};

  initial begin
    reset = 1; len = 4'd5; early_done = 0; mem_req = 0;
    mem_ready = 0; mdu_start = 0; mdu_done = 0; exc_req = 0;
    exc_cause_in = 0; irq = 0; irq_en = 0;
    nxn(2);
    chk("rst_step", int'(step), 1);
    chk("rst_retire", int'(retire), 0);
    chk("rst_exc", int'(exc_entry), 0);
    reset = 0;

    for (int c = 0; c < 11; c++) begin
      chk("base_step", int'(step), seq[c]);
      chk("base_retire", int'(retire), (c == 5 || c == 10) ? 1 : 0);
      if (c < 10) nx();
    end

    nxn(2);
    chk("early_s2", int'(step), 4);
    early_done = 1;
    nx();
    early_done = 0;
    chk("early_step", int'(step), 1);
    chk("early_retire", int'(retire), 1);

    len = 4'd1;
    nxn(2);
    len = 4'd5;
    nx();
    chk("clamp_step", int'(step), 1);
    chk("clamp_retire", int'(retire), 1);

    nxn(3);
    mem_req = 1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      #1;
      chk("mem_hold", int'(step), 8);
      chk("mem_stall", int'(stall), (i < 4) ? 1 : 0);
      nx();
    end
    mem_req = 0; mem_ready = 0;
    chk("mem_adv", int'(step), 16);
    nx();
    chk("mem_retire", int'(retire), 1);

    nxn(3);
    mem_req = 1;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i == 6);
      #1;
      chk("rdy_stall", int'(stall), (i < 6) ? 1 : 0);
      nx();
    end
    mem_req = 0; mem_ready = 0;
    chk("rdy_wins_bto", int'(bus_timeout), 0);
    chk("rdy_wins_step", int'(step), 16);
    nx();

    nxn(3);
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 7; i++) begin
      chk("to_hold", int'(step), 8);
      nx();
    end
    mem_req = 0;
    chk("to_bto", int'(bus_timeout), 1);
    chk("to_entry", int'(exc_entry), 1);
    chk("to_cause", int'(exc_cause), 7);
    chk("to_step", int'(step), 0);
    nx();
    chk("to_refetch", int'(step), 1);

    nxn(2);
    for (int i = 0; i < 11; i++) begin
      mdu_start = (i == 0);
      mdu_done = (i == 10);
      #1;
      chk("mdu_hold", int'(step), 4);
      chk("mdu_stall", int'(stall), (i < 10) ? 1 : 0);
      nx();
    end
    mdu_start = 0; mdu_done = 0;
    chk("mdu_adv", int'(step), 8);
    nxn(2);

    nxn(2);
    exc_req = 1; exc_cause_in = 5'd8;
    nx();
    exc_req = 0;
    chk("exc_entry", int'(exc_entry), 1);
    chk("exc_cause", int'(exc_cause), 8);
    chk("exc_noret", int'(retire), 0);
    nx();
    chk("exc_refetch", int'(step), 1);

    irq = 1; irq_en = 1;
    nxn(5);
    chk("irq_retire", int'(retire), 1);
    chk("irq_ack", int'(irq_ack), 1);
    chk("irq_entry", int'(exc_entry), 1);
    chk("irq_cause", int'(exc_cause), 0);
    irq_en = 0;
    nx();
    chk("irq_refetch", int'(step), 1);

    nxn(5);
    chk("irqm_retire", int'(retire), 1);
    chk("irqm_ack", int'(irq_ack), 0);
    chk("irqm_entry", int'(exc_entry), 0);
    irq = 0;

    nxn(3);
    mem_req = 1;
    nxn(2);
    reset = 1;
    nx();
    chk("rstm_step", int'(step), 1);
    chk("rstm_retire", int'(retire), 0);
    chk("rstm_entry", int'(exc_entry), 0);
    chk("rstm_ack", int'(irq_ack), 0);
    chk("rstm_bto", int'(bus_timeout), 0);
    reset = 0; mem_req = 0;

    for (int i = 0; i < 600; i++) begin
      len = LEN_W'($urandom_range(0, 15));
      early_done = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      mdu_start = ($urandom_range(0, 15) == 0);
      mdu_done = ($urandom_range(0, 3) == 0);
      exc_req = ($urandom_range(0, 15) == 0);
      exc_cause_in = 5'($urandom_range(0, 31));
      irq = ($urandom_range(0, 1) == 1);
      irq_en = ($urandom_range(0, 1) == 1);
      nx();
    end
    early_done = 0; mem_req = 0; mem_ready = 0; mdu_start = 0;
    mdu_done = 0; exc_req = 0; irq = 0; irq_en = 0;
    nxn(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
